mux4to1_tdm_tx: RTL and testbench
=================================

// Module: mux4to1_tdm_tx
// PURPOSE
//  Transmit end of the 4-channel select/data link: collects words from four
//  producer channels and time-multiplexes them onto one data line plus a 2-bit
//  select. The receive end is the 1-to-4 demux slice, which routes the data
//  line to out0..out3 by select.
//  Per-channel one-word buffers, round-robin arbitration, registered output.
// PARAMETERS
//  WIDTH  1  data bits per channel word; 1 matches the demux slice data input.
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  in_data    in   4*WIDTH  channel i word at [i*WIDTH +: WIDTH]
//  in_valid   in   4        channel i offers a word
//  in_ready   out  4        channel i buffer can accept a word
//  out_a      out  WIDTH    muxed data, drives demux data input
//  out_s      out  2        channel index of out_a, drives demux select
//  out_valid  out  1        out_a/out_s hold a valid word
//  out_ready  in   1        sink accepts the word this cycle
// BEHAVIOUR
//  Reset, async on rst rising, held while rst=1:
//   buf_full=4'b0000, rr_ptr=0, out_valid=0, out_a=0, out_s=2'b00.
//   in_ready=4'b0000 while rst=1 (combinational gate); 4'b1111 after release.
//   Reset mid-operation discards all buffered and in-flight words.
//  Input side, per channel i:
//   in_ready[i] = !buf_full[i] && !rst. No pass-through path.
//   in_valid[i] && in_ready[i] at an edge -> buf[i] <= word, buf_full[i] <= 1.
//  Arbitration:
//   load = (!out_valid || out_ready) && |buf_full.
//   grant g = first i with buf_full[i], searching rr_ptr, rr_ptr+1, ... mod 4.
//  On load at an edge:
//   out_a <= buf[g], out_s <= g, out_valid <= 1, buf_full[g] <= 0,
//   rr_ptr <= g+1, wrapping 3 -> 0.
//  If !load && out_valid && out_ready, out_valid <= 0. out_a/out_s keep their
//   last values.
//  While out_valid && !out_ready: out_a, out_s, out_valid are frozen and all
//   buffers hold. Input capture continues into non-full buffers.
//  Simultaneous events:
//   - A channel granted at edge k has in_ready=0 at edge k, so its next
//     capture happens at edge k+1 at the earliest.
//   - Output drain and new load in the same edge give back-to-back words;
//     aggregate throughput is 1 word/cycle.
//   - Each channel is limited to 1 word per 2 cycles.
//  Latency: word captured at edge k appears with out_valid=1 after edge k+1,
//   given an idle output and highest round-robin priority.
//  Fairness: a continuously requesting channel waits at most 3 grants.
//  Ordering: words from one channel leave in arrival order; no loss or
//   duplication.
// STRUCTURE
//  Package tdm_link_pkg, shared with the demux slice:
//   NUM_CH=4, SEL_W=2, typedef logic [SEL_W-1:0] ch_sel_t.
//  Sub-module rr_arbiter4 (combinational):
//   inputs req[3:0] and ptr; outputs gnt_idx and gnt_any.
//  This module holds the buffers, rr_ptr and the output register.
// TESTING
//  1 Reset: rst=1 with in_valid=4'b1111 -> out_valid=0, out_s=0, in_ready=0000;
//    after release in_ready=1111.
//  2 Single word: ch2 in_data bit=1 valid one cycle, out_ready=1 -> out_valid=1,
//    out_s=2, out_a=1 after 2nd edge; out_valid=0 next cycle.
//  3 All four channels loaded at the same edge with bits 1,0,1,1, out_ready=1
//    -> out_s=0,1,2,3 and out_a=1,0,1,1 on 4 consecutive cycles; rr_ptr ends
//    at 0.
//  4 Backpressure: out_ready=0 for 6 cycles while ch0..ch3 send -> out_a/out_s
//    stable, in_ready drops to 0 per full buffer; after release, all 4 words
//    are delivered exactly once.
//  5 Fairness: ch0 and ch3 valid every cycle, out_ready=1 -> out_s alternates
//    0,3,0,3 with no starvation.
//  6 Mid-operation reset: rst pulse with 3 buffers full and out_valid=1 ->
//    outputs return to reset values immediately; post-reset output contains
//    only new words.
//  Loopback check: out_a/out_s feed the demux slice, and its out[out_s] equals
//    out_a on every valid cycle.

Source files
------------

// File: rtl/mux4to1_tdm_tx_pkg.sv
// Shared definitions for the 4-channel select/data link (mux transmit and
// demux receive slices).
package tdm_link_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0]  ch_sel_t;
    typedef logic [NUM_CH-1:0] ch_mask_t;

    // Successor channel in round-robin order; 3 wraps to 0 through the 2-bit width.
    function automatic ch_sel_t next_ch(input ch_sel_t ch);
        return ch + ch_sel_t'(2'd1);
    endfunction

endpackage

// File: rtl/mux4to1_tdm_tx_if.sv
// Producer-side and sink-side signals of the TDM transmitter, bundled for
// connection between the channel producers/sink (master) and the mux (slave).
interface mux4to1_tdm_tx_if
    import tdm_link_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic [NUM_CH*WIDTH-1:0] in_data;
    ch_mask_t                in_valid;
    ch_mask_t                in_ready;
    logic [WIDTH-1:0]        out_a;
    ch_sel_t                 out_s;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_a,
        input  out_s,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_a,
        output out_s,
        output out_valid
    );

endinterface

// File: rtl/mux4to1_tdm_tx_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: grants the first requester found
// starting at ptr and moving upward modulo 4.
module rr_arbiter4
    import tdm_link_pkg::*;
(
    input  ch_mask_t req,
    input  ch_sel_t  ptr,
    output ch_sel_t  gnt_idx,
    output logic     gnt_any
);

    ch_mask_t rot_s;
    ch_sel_t  off_s;

    // Rotate requests so bit 0 is the highest-priority channel, then priority-encode.
    always_comb begin
        rot_s = req;
        off_s = ch_sel_t'(2'd0);
        case (ptr)
            2'd0:    rot_s = req;
            2'd1:    rot_s = {req[0],   req[3:1]};
            2'd2:    rot_s = {req[1:0], req[3:2]};
            2'd3:    rot_s = {req[2:0], req[3]};
            default: rot_s = req;
        endcase
        casez (rot_s)
            4'b???1: off_s = ch_sel_t'(2'd0);
            4'b??10: off_s = ch_sel_t'(2'd1);
            4'b?100: off_s = ch_sel_t'(2'd2);
            4'b1000: off_s = ch_sel_t'(2'd3);
            default: off_s = ch_sel_t'(2'd0);
        endcase
        gnt_idx = ptr + off_s;
        gnt_any = |req;
    end

endmodule

// File: rtl/mux4to1_tdm_tx.sv
// Transmit end of the 4-channel select/data link: one-word buffer per channel,
// round-robin selection and a registered data/select output toward the demux.
module mux4to1_tdm_tx
    import tdm_link_pkg::*;
#(
    parameter int WIDTH = 1
)
(
    input  logic             clk,
    input  logic             rst,
    mux4to1_tdm_tx_if.slave  bus
);

    logic [WIDTH-1:0] buf_r [NUM_CH];
    ch_mask_t         buf_full_r;
    ch_sel_t          rr_ptr_r;
    logic [WIDTH-1:0] out_a_r;
    ch_sel_t          out_s_r;
    logic             out_valid_r;

    ch_mask_t         in_ready_s;
    ch_mask_t         capture_s;
    ch_mask_t         release_s;
    ch_sel_t          gnt_idx_s;
    logic             gnt_any_s;
    logic             load_s;

    // in_ready is gated by rst directly so producers see 0 during reset.
    assign in_ready_s = ~buf_full_r & {NUM_CH{~rst}};
    assign capture_s  = bus.in_valid & in_ready_s;
    assign load_s     = (~out_valid_r | bus.out_ready) & gnt_any_s;
    assign release_s  = load_s ? (ch_mask_t'(4'b0001) << gnt_idx_s) : {NUM_CH{1'b0}};

    rr_arbiter4 u_arb (
        .req     (buf_full_r),
        .ptr     (rr_ptr_r),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Buffer occupancy: a granted channel is full at its grant edge, so release and capture never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_full_r <= {NUM_CH{1'b0}};
        end else begin
            buf_full_r <= (buf_full_r & ~release_s) | capture_s;
        end
    end

    // Per-channel word storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                buf_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (capture_s[i]) begin
                    buf_r[i] <= bus.in_data[i*WIDTH +: WIDTH];
                end else begin
                    buf_r[i] <= buf_r[i];
                end
            end
        end
    end

    // Output register and round-robin pointer; data/select hold their last values when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a_r     <= {WIDTH{1'b0}};
            out_s_r     <= ch_sel_t'(2'd0);
            out_valid_r <= 1'b0;
            rr_ptr_r    <= ch_sel_t'(2'd0);
        end else if (load_s) begin
            out_a_r     <= buf_r[gnt_idx_s];
            out_s_r     <= gnt_idx_s;
            out_valid_r <= 1'b1;
            rr_ptr_r    <= next_ch(gnt_idx_s);
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_a     = out_a_r;
    assign bus.out_s     = out_s_r;
    assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_mux4to1_tdm_tx.sv
// Directed bench for mux4to1_tdm_tx: reset, single word, round-robin order,
// backpressure, fairness and mid-operation reset, with a demux loopback model.
module tb_mux4to1_tdm_tx;
    import tdm_link_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic dmx_out [NUM_CH];

    mux4to1_tdm_tx_if #(.WIDTH(1)) bus ();

    mux4to1_tdm_tx #(.WIDTH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive-side demux model: routes out_a to the output selected by out_s.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) dmx_out[i] = 1'b0;
        dmx_out[bus.out_s] = bus.out_a;
    end

    localparam logic [3:0] BP_VALID [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    localparam logic [3:0] BP_DATA  [6] = '{4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    localparam logic [3:0] BP_RDY   [6] = '{4'b1110, 4'b1101, 4'b1001, 4'b0001, 4'b0000, 4'b0000};
    localparam logic       BP_OV    [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [1:0] BP_S     [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    localparam logic       BP_A     [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic       AF_A     [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid  = 4'b0000;
        bus.in_data   = 4'b0000;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = 4'b1111;
        bus.out_ready = 1'b1;
        step();
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        vectors++; if (bus.out_s !== 2'd0) begin miscompares++; $display("FAIL reset_out_s got %0d exp 0", bus.out_s); end
        vectors++; if (bus.out_a !== 1'b0) begin miscompares++; $display("FAIL reset_out_a got %b exp 0", bus.out_a); end
        vectors++; if (bus.in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready got %b exp 0000", bus.in_ready); end
        bus.in_valid = 4'b0000;
        rst = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 4'b1111) begin miscompares++; $display("FAIL release_in_ready got %b exp 1111", bus.in_ready); end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL release_out_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_single();
        bus.in_data  = 4'b0100;
        bus.in_valid = 4'b0100;
        step();
        bus.in_valid = 4'b0000;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_e1_valid got %b exp 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 4'b1011) begin miscompares++; $display("FAIL single_e1_in_ready got %b exp 1011", bus.in_ready); end
        step();
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_e2_valid got %b exp 1", bus.out_valid); end
        vectors++; if (bus.out_s !== 2'd2) begin miscompares++; $display("FAIL single_e2_s got %0d exp 2", bus.out_s); end
        vectors++; if (bus.out_a !== 1'b1) begin miscompares++; $display("FAIL single_e2_a got %b exp 1", bus.out_a); end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single_e3_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_all_four();
        do_reset();
        bus.in_data  = 4'b1101;
        bus.in_valid = 4'b1111;
        step();
        bus.in_valid = 4'b0000;
        vectors++; if (bus.in_ready !== 4'b0000) begin miscompares++; $display("FAIL all4_in_ready got %b exp 0000", bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL all4_valid[%0d] got %b exp 1", k, bus.out_valid); end
            vectors++; if (bus.out_s !== 2'(k)) begin miscompares++; $display("FAIL all4_s[%0d] got %0d exp %0d", k, bus.out_s, k); end
            vectors++; if (dmx_out[k] !== AF_A[k]) begin miscompares++; $display("FAIL all4_loopback[%0d] got %b exp %b", k, dmx_out[k], AF_A[k]); end
        end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL all4_drained got %b exp 0", bus.out_valid); end
        // Pointer back at 0: ch0 must win over ch3 when both load together.
        bus.in_data  = 4'b1000;
        bus.in_valid = 4'b1001;
        step();
        bus.in_valid = 4'b0000;
        step();
        vectors++; if (bus.out_s !== 2'd0 || bus.out_a !== 1'b0) begin miscompares++; $display("FAIL ptr_wrap_first got s=%0d a=%b exp s=0 a=0", bus.out_s, bus.out_a); end
        step();
        vectors++; if (bus.out_s !== 2'd3 || bus.out_a !== 1'b1) begin miscompares++; $display("FAIL ptr_wrap_second got s=%0d a=%b exp s=3 a=1", bus.out_s, bus.out_a); end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = BP_VALID[k];
            bus.in_data  = BP_DATA[k];
            step();
            vectors++; if (bus.out_valid !== BP_OV[k]) begin miscompares++; $display("FAIL bp_valid[%0d] got %b exp %b", k, bus.out_valid, BP_OV[k]); end
            vectors++; if (bus.in_ready !== BP_RDY[k]) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %b exp %b", k, bus.in_ready, BP_RDY[k]); end
            if (k >= 1) begin
                vectors++; if (bus.out_s !== 2'd0 || bus.out_a !== 1'b1) begin miscompares++; $display("FAIL bp_hold[%0d] got s=%0d a=%b exp s=0 a=1", k, bus.out_s, bus.out_a); end
            end
        end
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_s !== BP_S[k] || bus.out_a !== BP_A[k]) begin
                miscompares++; $display("FAIL bp_drain[%0d] got v=%b s=%0d a=%b exp v=1 s=%0d a=%b", k, bus.out_valid, bus.out_s, bus.out_a, BP_S[k], BP_A[k]);
            end
        end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_dup got %b exp 0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 4'b1111) begin miscompares++; $display("FAIL bp_empty_ready got %b exp 1111", bus.in_ready); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_s;
        bus.out_ready = 1'b1;
        bus.in_data   = 4'b0001;
        bus.in_valid  = 4'b1001;
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL fair_start got %b exp 0", bus.out_valid); end
        // Pointer is 1 after the previous test, so ch3 leads.
        for (int k = 0; k < 6; k++) begin
            step();
            exp_s = (k % 2 == 0) ? 2'd3 : 2'd0;
            vectors++; if (bus.out_valid !== 1'b1 || bus.out_s !== exp_s || bus.out_a !== (exp_s == 2'd0)) begin
                miscompares++; $display("FAIL fair[%0d] got v=%b s=%0d a=%b exp v=1 s=%0d a=%b", k, bus.out_valid, bus.out_s, bus.out_a, exp_s, (exp_s == 2'd0));
            end
        end
        bus.in_valid = 4'b0000;
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_data   = 4'b1111;
        bus.in_valid  = 4'b1111;
        step();
        bus.in_valid = 4'b0000;
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 4'b0001) begin miscompares++; $display("FAIL mid_pre got v=%b rdy=%b exp v=1 rdy=0001", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_s !== 2'd0 || bus.out_a !== 1'b0) begin
            miscompares++; $display("FAIL mid_async got v=%b s=%0d a=%b exp v=0 s=0 a=0", bus.out_valid, bus.out_s, bus.out_a);
        end
        vectors++; if (bus.in_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_in_ready got %b exp 0000", bus.in_ready); end
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data   = 4'b0010;
        bus.in_valid  = 4'b0010;
        step();
        bus.in_valid = 4'b0000;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale got %b exp 0", bus.out_valid); end
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_s !== 2'd1 || bus.out_a !== 1'b1) begin
            miscompares++; $display("FAIL mid_new got v=%b s=%0d a=%b exp v=1 s=1 a=1", bus.out_valid, bus.out_s, bus.out_a);
        end
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_after got %b exp 0", bus.out_valid); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b0;
        bus.in_valid  = 4'b0000;
        bus.in_data   = 4'b0000;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
